// File: rtl/whack_pkg.sv
// Shared scancode and hole-code definitions for the whack-a-mole input path.
// Used by the PS/2 encoder front end and by matchLogic.
package whack_pkg;

    // Set-2 make codes for the game keys, plus the break and extended prefixes
    localparam logic [7:0] SC_KEY1  = 8'h16;
    localparam logic [7:0] SC_KEY2  = 8'h1E;
    localparam logic [7:0] SC_KEY3  = 8'h26;
    localparam logic [7:0] SC_KEY4  = 8'h25;
    localparam logic [7:0] SC_KEY5  = 8'h2E;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Hole codes as consumed by userGameInput
    localparam logic [2:0] HIT_NONE = 3'b000;
    localparam logic [2:0] HIT_H1   = 3'b001;
    localparam logic [2:0] HIT_H2   = 3'b010;
    localparam logic [2:0] HIT_H3   = 3'b011;
    localparam logic [2:0] HIT_H4   = 3'b100;
    localparam logic [2:0] HIT_H5   = 3'b101;

    // Five holes plus Enter tracked by the repeat filter
    localparam int NUM_KEYS = 6;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Make code -> hole code; anything unmapped (including Enter) is HIT_NONE
    function automatic logic [2:0] sc_to_hit(input logic [7:0] sc);
        case (sc)
            SC_KEY1: sc_to_hit = HIT_H1;
            SC_KEY2: sc_to_hit = HIT_H2;
            SC_KEY3: sc_to_hit = HIT_H3;
            SC_KEY4: sc_to_hit = HIT_H4;
            SC_KEY5: sc_to_hit = HIT_H5;
            default: sc_to_hit = HIT_NONE;
        endcase
    endfunction

    // Make code -> one-hot pressed-mask bit (bit 5 = Enter)
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] sc);
        case (sc)
            SC_KEY1:  key_onehot = 6'b000001;
            SC_KEY2:  key_onehot = 6'b000010;
            SC_KEY3:  key_onehot = 6'b000100;
            SC_KEY4:  key_onehot = 6'b001000;
            SC_KEY5:  key_onehot = 6'b010000;
            SC_ENTER: key_onehot = 6'b100000;
            default:  key_onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the keyboard lines, samples on falling
// ps2_clk edges and assembles 11-bit frames. byte_valid / frame_err are
// combinational pulses in the cycle of the deciding strobe; the parent registers them.
module ps2_frame_rx
    import whack_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   clk_s, dat_s, strobe, timeout;

    rx_state_t state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          par_q, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;

    // Synchronisers reset to the idle-high line level so reset never fakes an edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];
    assign strobe  = clk_prev & ~clk_s;
    assign rx_byte = shreg;

    // Frame state and datapath registers; reset drops any partial frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            par_q   <= par_n;
            to_cnt  <= to_cnt_n;
        end
    end

    // Next-state, bit assembly, frame checks and the mid-frame watchdog
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        par_n      = par_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        // A strobe in the same cycle wins over the watchdog
        timeout    = (state != RX_IDLE) && !strobe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

        case (state)
            RX_IDLE: if (strobe) begin
                if (!dat_s) begin
                    state_n   = RX_DATA;
                    bit_cnt_n = '0;
                end else begin
                    frame_err = 1'b1;
                end
            end
            RX_DATA: if (strobe) begin
                shreg_n   = {dat_s, shreg[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = RX_PARITY;
            end
            RX_PARITY: if (strobe) begin
                par_n   = dat_s;
                state_n = RX_STOP;
            end
            RX_STOP: if (strobe) begin
                if (dat_s && (^{shreg, par_q})) byte_valid = 1'b1;
                else                            frame_err  = 1'b1;
                state_n = RX_IDLE;
            end
        endcase

        if (timeout) begin
            frame_err = 1'b1;
            state_n   = RX_IDLE;
        end

        to_cnt_n = (strobe || state == RX_IDLE || timeout) ? '0 : to_cnt + TW'(1);
    end

endmodule

// File: rtl/ps2_hit_encoder.sv
// PS/2 keyboard front end for the whack-a-mole datapath: turns scancodes into
// one-cycle hole codes (userGameInput) and a start-game pulse.
// Optional build macro REPEAT_FILTER_EN: suppress typematic repeats with a
// pressed-key mask so each physical press yields one pulse.
module ps2_hit_encoder
    import whack_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [2:0] hit,
    output logic       start_game,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    logic       brk, ext;
    logic       is_ctrl, is_make, emit, start_d;
    logic [2:0] hit_d;
`ifdef REPEAT_FILTER_EN
    logic [NUM_KEYS-1:0] pressed, key;
    logic                is_rel;
`endif

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    // Classify the received byte and decide whether it produces an output pulse
    always_comb begin
        is_ctrl = (rx_byte == SC_EXT) || (rx_byte == SC_BREAK);
        is_make = rx_valid && !is_ctrl && !brk && !ext;
`ifdef REPEAT_FILTER_EN
        key     = key_onehot(rx_byte);
        is_rel  = rx_valid && !is_ctrl && brk && !ext;
        emit    = is_make && ((key & pressed) == '0);
`else
        emit    = is_make;
`endif
        hit_d   = emit ? sc_to_hit(rx_byte) : HIT_NONE;
        start_d = emit && (rx_byte == SC_ENTER);
    end

    // Prefix flags: E0/F0 arm them, the next ordinary byte consumes both
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

`ifdef REPEAT_FILTER_EN
    // Pressed mask: set on first make, cleared by the matching break sequence
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        pressed <= '0;
        else if (is_make) pressed <= pressed | key;
        else if (is_rel)  pressed <= pressed & ~key;
    end
`endif

    // Output registers: one clock after the deciding strobe, one cycle wide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit        <= HIT_NONE;
            start_game <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            hit        <= hit_d;
            start_game <= start_d;
            frame_err  <= rx_err;
        end
    end

endmodule
